// File: rtl/mips_ifu_pkg.sv
// Shared types and constants for the MIPS instruction fetch unit.
package mips_ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Fetch sequencer: nothing outstanding, live request outstanding, wrong-path request outstanding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  // One prefetched instruction together with the sequential successor address
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clears the byte offset so a redirect target is always a word address
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO for the fetch unit. Flush wins over push/pop, a push into a
// full buffer is accepted only when a pop frees the head in the same cycle.
// The head entry reads as all-zero while the buffer is empty.
module fetch_buffer
  import mips_ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_i,
  input  fetch_entry_t       entry_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [CW-1:0]      count_o,
  output logic               head_valid_o,
  output fetch_entry_t       head_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s;
  logic          do_pop_s;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop_i && (count_q != {CW{1'b0}});
    do_push_s = push_i && ((count_q < DEPTH_C) || do_pop_s);
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = entry_i;
        wr_ptr_d        = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{(CW-1){1'b0}}, do_push_s} - {{(CW-1){1'b0}}, do_pop_s};
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head mux straight from storage; zero (NOP) when empty
  always_comb begin
    head_valid_o = (count_q != {CW{1'b0}});
    if (head_valid_o) begin
      head_o = mem_q[rd_ptr_q];
    end else begin
      head_o = '0;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: program counter, single-outstanding fetch
// sequencer and prefetch buffer feeding the IF/ID register.
// Optional feature macro: IFU_ALIGN_CHECK_EN (misaligned redirect halts fetch
// and raises a sticky misalign_o flag).
module instruction_fetch_unit
  import mips_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        misalign_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          halted_s;
  logic [31:0]   target_s;
  logic          push_s;
  logic          pop_s;
  logic          space_s;
  logic          req_s;
  logic [CW:0]   next_count_s;
  logic [CW-1:0] fb_count_s;
  logic          fb_valid_s;
  fetch_entry_t  fb_head_s;
  fetch_entry_t  fb_entry_s;

`ifdef IFU_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic misalign_hit_s;

  assign misalign_hit_s = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign halted_s       = misalign_q;
  assign target_s       = redirect_pc_i;
  assign misalign_o     = misalign_q;

  // Sticky misalignment flag; only reset clears it
  always_comb begin
    if (misalign_hit_s) begin
      misalign_d = 1'b1;
    end else begin
      misalign_d = misalign_q;
    end
  end

  // Misalignment flag register
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`else
  assign halted_s   = 1'b0;
  assign target_s   = align_word(redirect_pc_i);
  assign misalign_o = 1'b0;
`endif

  // Buffer-side handshake and request decision; pc_q equals the outstanding
  // fetch address + 4 while in WAIT, so it is the pc_plus4 of the response
  always_comb begin
    push_s       = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_i;
    pop_s        = fb_valid_s && !stall_i && !redirect_i;
    next_count_s = {1'b0, fb_count_s} + {{CW{1'b0}}, push_s} - {{CW{1'b0}}, pop_s};
    space_s      = (next_count_s < DEPTH_C);
    req_s        = !reset && !redirect_i && !halted_s && space_s &&
                   ((state_q == ST_IDLE) || imem_rvalid_i);
    fb_entry_s.pc_plus4 = pc_q;
    fb_entry_s.instr    = imem_rdata_i;
  end

  // Fetch sequencer next state and fetch PC
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (redirect_i) begin
          state_d = imem_rvalid_i ? ST_IDLE : ST_DROP;
        end else if (imem_rvalid_i) begin
          state_d = req_s ? ST_WAIT : ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_d = req_s ? ST_WAIT : ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (redirect_i) begin
      pc_d = target_s;
    end else if (req_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // Sequencer and PC registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_buffer (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push_s),
    .entry_i      (fb_entry_s),
    .pop_i        (pop_s),
    .flush_i      (redirect_i),
    .count_o      (fb_count_s),
    .head_valid_o (fb_valid_s),
    .head_o       (fb_head_s)
  );

  assign imem_req_o  = req_s;
  assign imem_addr_o = pc_q;
  assign valid_o     = fb_valid_s;
  assign pc_o        = fb_head_s.pc_plus4;
  assign instr_o     = fb_head_s.instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table of latency scenarios,
// directed stall/redirect/misalign sequences, then randomized traffic against
// a program-order scoreboard and a variable-latency memory model.
module tb_instruction_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        misalign_o;

  instruction_fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus controls
  bit          rst_v, stall_v, redir_v, inject_spur;
  logic [31:0] redir_pc_v;
  int          lat_mode;   // 0 = random 1..3, else fixed latency

  // reference model state
  int          buffered;
  logic [31:0] exp_req_addr, exp_cons;
  bit          mem_busy, stale, halted_m, prev_rst;
  int          mem_due;
  logic [31:0] mem_addr;
  int          cyc;

  // per-cycle samples
  bit          s_req, s_valid, s_misalign, s_pop;
  logic [31:0] s_addr, s_pc, s_pop_pc;
  int          delivered;
  logic [31:0] first_pc;
  bit          got_first;

  int total, bad;

  typedef struct {
    int          lat;
    int          ncyc;
    int          exp_deliv;
    logic [31:0] exp_first_pc;
  } vec_t;

  vec_t vecs [4];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic        rv;
    logic [31:0] rd;
    bit          exp_valid, pop, push, sp, exp_req;
    int          lat;
    @(negedge clk);
    rv = 1'b0;
    rd = 32'h0;
    if (!rst_v && mem_busy && (cyc == mem_due)) begin
      rv = 1'b1;
      rd = instr_of(mem_addr);
    end else if (!rst_v && inject_spur && !mem_busy) begin
      rv = 1'b1;
      rd = 32'hDEAD_BEEF;
    end
    reset         = rst_v;
    stall_i       = stall_v;
    redirect_i    = redir_v;
    redirect_pc_i = redir_pc_v;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    #1;
    s_req      = imem_req_o;
    s_addr     = imem_addr_o;
    s_valid    = valid_o;
    s_pc       = pc_o;
    s_misalign = misalign_o;
    s_pop      = 1'b0;
    if (rst_v) begin
      check("rst_req", 32'(imem_req_o), 32'd0);
      if (prev_rst) begin
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
      end
      buffered     = 0;
      exp_req_addr = RPC;
      exp_cons     = RPC;
      mem_busy     = 1'b0;
      stale        = 1'b0;
      halted_m     = 1'b0;
      prev_rst     = 1'b1;
      cyc          = 0;
      return;
    end
    prev_rst  = 1'b0;
    exp_valid = (buffered != 0);
    check("valid", 32'(valid_o), 32'(exp_valid));
    if (exp_valid) begin
      check("head_pc", pc_o, exp_cons + 32'd4);
      check("head_instr", instr_o, instr_of(exp_cons));
    end else begin
      check("empty_pc", pc_o, 32'd0);
      check("empty_instr", instr_o, 32'd0);
    end
    pop = exp_valid && !stall_v && !redir_v;
    if (pop) begin
      s_pop    = 1'b1;
      s_pop_pc = pc_o;
      delivered++;
      if (!got_first) first_pc = pc_o;
      got_first = 1'b1;
      exp_cons  = exp_cons + 32'd4;
    end
    push    = rv && mem_busy && !stale && !redir_v;
    sp      = (buffered + int'(push) - int'(pop)) < DEPTH;
    exp_req = !redir_v && !halted_m && sp && (!mem_busy || rv);
    check("req", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) check("req_addr", imem_addr_o, exp_req_addr);
    check("misalign", 32'(misalign_o), 32'(halted_m));
    if (redir_v) buffered = 0;
    else buffered = buffered + int'(push) - int'(pop);
    if (rv && mem_busy) begin
      mem_busy = 1'b0;
      stale    = 1'b0;
    end
    if (redir_v && mem_busy) stale = 1'b1;
    if (exp_req) begin
      lat          = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
      mem_busy     = 1'b1;
      stale        = 1'b0;
      mem_addr     = imem_addr_o;
      mem_due      = cyc + lat;
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (redir_v) begin
`ifdef IFU_ALIGN_CHECK_EN
      if (redir_pc_v[1:0] != 2'b00) halted_m = 1'b1;
      exp_req_addr = redir_pc_v;
      exp_cons     = redir_pc_v;
`else
      exp_req_addr = {redir_pc_v[31:2], 2'b00};
      exp_cons     = {redir_pc_v[31:2], 2'b00};
`endif
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    stall_v = 1'b0;
    redir_v = 1'b0;
    step();
    step();
    rst_v = 1'b0;
  endtask

  task automatic wait_pop(input string nm, input logic [31:0] exp_pc);
    int k;
    k = 0;
    step();
    while (!s_pop && k < 40) begin
      step();
      k++;
    end
    if (!s_pop) begin
      total++;
      bad++;
      $display("FAIL %s: no instruction delivered within 40 cycles, expected pc %h", nm, exp_pc);
    end else begin
      check(nm, s_pop_pc, exp_pc);
    end
  endtask

  task automatic wait_req(input string nm, input logic [31:0] exp_addr, output int req_cyc);
    int k;
    k = 0;
    req_cyc = -1;
    step();
    while (!s_req && k < 40) begin
      step();
      k++;
    end
    if (!s_req) begin
      total++;
      bad++;
      $display("FAIL %s: no request within 40 cycles, expected addr %h", nm, exp_addr);
    end else begin
      req_cyc = cyc - 1;
      check(nm, s_addr, exp_addr);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rc;
    int nreq;
    total = 0; bad = 0; cyc = 0;
    rst_v = 1'b1; stall_v = 1'b0; redir_v = 1'b0; inject_spur = 1'b0;
    redir_pc_v = 32'h0; lat_mode = 1; prev_rst = 1'b0;
    delivered = 0; got_first = 1'b0; first_pc = 32'h0;
    mem_busy = 1'b0; stale = 1'b0; halted_m = 1'b0; buffered = 0;

    // deliveries in first N cycles after reset with latency L, no stall:
    // first valid at cycle L+1, then one every L cycles
    vecs[0] = '{lat: 1, ncyc: 20, exp_deliv: 18, exp_first_pc: 32'h0040_0004};
    vecs[1] = '{lat: 2, ncyc: 20, exp_deliv: 9,  exp_first_pc: 32'h0040_0004};
    vecs[2] = '{lat: 3, ncyc: 20, exp_deliv: 6,  exp_first_pc: 32'h0040_0004};
    vecs[3] = '{lat: 3, ncyc: 30, exp_deliv: 9,  exp_first_pc: 32'h0040_0004};

    for (int i = 0; i < 4; i++) begin
      lat_mode = vecs[i].lat;
      do_reset();
      delivered = 0;
      got_first = 1'b0;
      first_pc  = 32'h0;
      repeat (vecs[i].ncyc) step();
      check("tbl_delivered", 32'(delivered), 32'(vecs[i].exp_deliv));
      check("tbl_first_pc", first_pc, vecs[i].exp_first_pc);
    end

    // stall fills the buffer, spurious rvalid in IDLE is ignored
    lat_mode = 1;
    do_reset();
    inject_spur = 1'b1;
    step();
    inject_spur = 1'b0;
    repeat (3) step();
    stall_v = 1'b1;
    for (int k = 0; k < 5; k++) begin
      inject_spur = (k == 2);
      step();
      check("stall_head_pc", s_pc, exp_cons + 32'd4);
    end
    inject_spur = 1'b0;
    check("stall_req_low", 32'(s_req), 32'd0);
    check("stall_valid", 32'(s_valid), 32'd1);

    // redirect together with stall while full
    redir_v = 1'b1;
    redir_pc_v = 32'h0040_0200;
    step();
    redir_v = 1'b0;
    stall_v = 1'b0;
    step();
    check("redir_flush_valid", 32'(s_valid), 32'd0);
    wait_pop("redir_stall_first_pc", 32'h0040_0204);

    // stall then in-order drain
    stall_v = 1'b1;
    repeat (6) step();
    check("stall2_req_low", 32'(s_req), 32'd0);
    stall_v = 1'b0;
    repeat (10) step();

    // redirect while a 3-cycle fetch is outstanding
    lat_mode = 3;
    do_reset();
    step();
    redir_v = 1'b1;
    redir_pc_v = 32'h0040_0100;
    step();
    redir_v = 1'b0;
    wait_req("drop_req_addr", 32'h0040_0100, rc);
    check("drop_req_cycle", 32'(rc), 32'd3);
    wait_pop("drop_first_pc", 32'h0040_0104);

    // misaligned redirect
    lat_mode = 1;
    do_reset();
    repeat (5) step();
    redir_v = 1'b1;
    redir_pc_v = 32'h0040_0102;
    step();
    redir_v = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    nreq = 0;
    repeat (10) begin
      step();
      if (s_req) nreq++;
    end
    check("halt_no_req", 32'(nreq), 32'd0);
    check("halt_misalign", 32'(s_misalign), 32'd1);
`else
    nreq = 0;
    wait_req("misalign_forced_addr", 32'h0040_0100, rc);
    check("misalign_tied_low", 32'(s_misalign), 32'd0);
`endif
    do_reset();
    step();
    check("misalign_after_reset", 32'(s_misalign), 32'd0);

    // randomized traffic
    lat_mode = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_v      = ($urandom_range(0, 999) < 3);
      stall_v    = ($urandom_range(0, 99) < 30);
      redir_v    = ($urandom_range(0, 99) < 5);
      redir_pc_v = RPC + (32'($urandom_range(0, 255)) << 2);
      step();
    end
    rst_v = 1'b0;
    stall_v = 1'b0;
    redir_v = 1'b0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the MIPS pipeline. It owns the program counter and issues word fetches to instruction memory over a request/response handshake. It buffers returned instructions with their PC+4 in a small prefetch FIFO and presents them to the IF/ID pipeline register. It honours the hazard unit's stall and the ID/EX redirect (branch/jump), discarding wrong-path fetches.

## Interface
- RESET_PC, 32'h0040_0000, PC loaded on reset (byte address, word aligned)
- FIFO_DEPTH, 2, prefetch entries; power of two, ≥2
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall_i  input  1  hazard stall; high holds FIFO head (same polarity as IF/ID enable-inhibit)
- redirect_i  input  1  taken branch/jump; flush and refetch
- redirect_pc_i  input  32  redirect target byte address
- imem_req_o  output  1  fetch request valid this cycle
- imem_addr_o  output  32  fetch byte address (current fetch PC)
- imem_rvalid_i  input  1  response valid; one per accepted request, ≥1 cycle after it
- imem_rdata_i  input  32  returned instruction word
- valid_o  output  1  FIFO head valid
- pc_o  output  32  head fetch address + 4 (to IF/ID pc_i)
- instr_o  output  32  head instruction (to IF/ID instr_i); 0 (NOP) when !valid_o
- misalign_o  output  1  sticky misaligned-redirect flag (IFU_ALIGN_CHECK_EN only; else tied 0)

## Operation
- Fetch FSM: IDLE (nothing outstanding), WAIT (one request outstanding, live), DROP (one outstanding, wrong-path).
- At most one outstanding request. Request is accepted in the cycle imem_req_o=1; fetch PC then advances by 4 (mod 2^32, wraps silently).
- imem_req_o = !reset & !redirect_i & !halted & space & (state==IDLE | (state!=IDLE & imem_rvalid_i)).
- space: (count + push − pop) < FIFO_DEPTH, where push = rvalid in WAIT, pop = valid_o & !stall_i.
- Transitions: IDLE→WAIT on req; WAIT→IDLE on rvalid without req; WAIT→WAIT on rvalid with req; WAIT→DROP on redirect_i without rvalid; DROP→IDLE on rvalid (data discarded) without req; DROP→WAIT on rvalid with req. redirect_i in DROP stays DROP.
- Push: rvalid in WAIT writes {fetch address+4, rdata} at tail. rvalid in DROP or IDLE is ignored.
- Redirect: empties FIFO (pointers, count to 0) and loads fetch PC ← redirect_pc_i. It overrides stall_i, push and pop in that cycle. An rvalid arriving in the redirect cycle is discarded.
- Simultaneous push and pop: count unchanged; full and pop permits push.
- Pointers wrap modulo FIFO_DEPTH. Outputs are driven from FIFO storage through head mux, with no combinational path from imem_rdata_i.

## Timing
- Reset values: state IDLE, PC=RESET_PC, count 0, valid_o 0, pc_o 0, instr_o 0, imem_req_o 0, misalign_o 0. Reset mid-transaction abandons the outstanding request; a late rvalid in IDLE is ignored.
- First request in first cycle after reset deasserts, imem_addr_o=RESET_PC.
- Fetch latency with 1-cycle memory: request cycle t, rvalid t+1, valid_o at t+2.
- Steady state with no stall and 1-cycle memory: one instruction per cycle.
- Redirect at cycle t: valid_o=0 at t+1. Target request at t+1 (IDLE/WAIT-free) or on the drop completion.
- Stall held indefinitely: FIFO fills to FIFO_DEPTH, then imem_req_o drops. pc_o/instr_o stay stable.

## Configuration
- IFU_ALIGN_CHECK_EN defined: redirect_pc_i[1:0]!=0 sets misalign_o (sticky until reset) and sets halted. Halted suppresses all further requests, while the FIFO still drains.
- Undefined: redirect_pc_i[1:0] forced to 00, misalign_o tied 0, no halt state.

## Structure
- Package mips_ifu_pkg: fetch FSM state enum, fetch-entry struct {pc_plus4[31:0], instr[31:0]}, default RESET_PC constant.
- Sub-module fetch_buffer: parameterised FIFO of entries with push, pop, flush, count, and head output. The top holds the FSM, PC and request logic.

## Test plan
- Reset then run, 1-cycle memory, no stall → requests at 0x00400000, 0x00400004…; valid_o from cycle 2, one instruction per cycle, pc_o=0x00400004 for the first instruction.
- Stall held 5 cycles with FIFO_DEPTH=2 → exactly 2 entries buffered, imem_req_o=0 until release. Head unchanged, then in-order drain.
- Redirect to 0x00400100 while WAIT → FSM enters DROP, the stale rvalid is discarded, and the next request uses 0x00400100. First valid pc_o=0x00400104.
- Redirect and stall together, FIFO full → FIFO emptied, valid_o=0 next cycle, and fetch resumes at target.
- 3-cycle memory latency → one request outstanding at a time and one instruction per 3 cycles, in order.
- IFU_ALIGN_CHECK_EN, redirect to 0x00400102 → misalign_o=1 and stays set, with no further imem_req_o until reset.
